// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: start/busy/done handshake and operand/result bus of the
// multi-cycle execute-stage ALU. The core controller drives the master side.
interface alu_multicycle_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             zero;

    modport master (
        output start, ALUOp, a, b,
        input  busy, done, Result, zero
    );

    modport slave (
        input  start, ALUOp, a, b,
        output busy, done, Result, zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU. Logic/arithmetic ops answer
// one cycle after start; with ALU_MULDIV_EN defined, unsigned MUL/DIVU/REMU
// run iteratively for WIDTH cycles (shift-add multiply, restoring divide).
// Without ALU_MULDIV_EN those opcodes decode as illegal and busy is tied low.
module alu_multicycle #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1000;

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0101;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t           state;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] sc_result;
    logic             sc_zero;

`ifdef ALU_MULDIV_EN
    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    logic             is_iter;
    logic             mode_mul;
    logic             mode_rem;
    // acc: product or partial remainder; xr: multiplier or dividend/quotient;
    // yr: multiplicand or divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] fin;
`endif

    // Single-cycle result and flag from the operands presented with start.
    always_comb begin
        sc_result = '0;
        case (bus.ALUOp)
            OP_AND:  sc_result = bus.a & bus.b;
            OP_OR:   sc_result = bus.a | bus.b;
            OP_ADD:  sc_result = bus.a + bus.b;
            OP_SUB:  sc_result = bus.a - bus.b;
            OP_NOR:  sc_result = ~(bus.a | bus.b);
            OP_SLTU: sc_result = bus.a - bus.b;
            default: sc_result = '0;
        endcase
        sc_zero = (bus.ALUOp == OP_SLTU) ? (bus.a < bus.b) : (sc_result == '0);
    end

`ifdef ALU_MULDIV_EN
    // One shift-add / restoring-divide step, plus the final result mux.
    always_comb begin
        is_iter    = (bus.ALUOp == OP_MUL) || (bus.ALUOp == OP_DIVU) ||
                     (bus.ALUOp == OP_REMU);
        mul_acc_nx = acc + (xr[0] ? yr : '0);
        div_shift  = {acc, xr[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, yr});
        div_diff   = div_shift - {1'b0, yr};
        rem_nx     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nx     = {xr[WIDTH-2:0], div_ge};
        fin        = mode_mul ? mul_acc_nx : (mode_rem ? rem_nx : quo_nx);
    end
`endif

    // Handshake FSM with registered outputs; a new start is taken in IDLE or DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            busy_q   <= 1'b0;
            cnt      <= '0;
            mode_mul <= 1'b0;
            mode_rem <= 1'b0;
            acc      <= '0;
            xr       <= '0;
            yr       <= '0;
`endif
        end else begin
            case (state)
`ifdef ALU_MULDIV_EN
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mode_mul) begin
                        acc <= mul_acc_nx;
                        xr  <= xr >> 1;
                        yr  <= yr << 1;
                    end else begin
                        acc <= rem_nx;
                        xr  <= quo_nx;
                    end
                    if (cnt == LAST_ITER) begin
                        result_q <= fin;
                        zero_q   <= (fin == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
`endif
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                    if (bus.start) begin
`ifdef ALU_MULDIV_EN
                        if (is_iter) begin
                            mode_mul <= (bus.ALUOp == OP_MUL);
                            mode_rem <= (bus.ALUOp == OP_REMU);
                            acc      <= '0;
                            cnt      <= '0;
                            xr       <= (bus.ALUOp == OP_MUL) ? bus.b : bus.a;
                            yr       <= (bus.ALUOp == OP_MUL) ? bus.a : bus.b;
                            busy_q   <= 1'b1;
                            state    <= RUN;
                        end else begin
                            result_q <= sc_result;
                            zero_q   <= sc_zero;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
`else
                        result_q <= sc_result;
                        zero_q   <= sc_zero;
                        done_q   <= 1'b1;
                        state    <= DONE;
`endif
                    end
                end
            endcase
        end
    end

`ifdef ALU_MULDIV_EN
    assign bus.busy = busy_q;
`else
    assign bus.busy = 1'b0;
`endif
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.zero   = zero_q;

endmodule
